// File: rtl/rate_decoder_if.sv
// rate_decoder_if: tick-stream input and rate-classification outputs of rate_decoder
//   pulse_in   : tick stream, one tick per high sample
//   freq_code  : last locked rate code
//   code_valid : freq_code is locked
//   mismatch   : last interval fit no class, or a timeout occurred
//   interval   : last measured tick interval in cycles
interface rate_decoder_if #(parameter int CNT_W = 28);
  logic             pulse_in;
  logic [1:0]       freq_code;
  logic             code_valid;
  logic             mismatch;
  logic [CNT_W-1:0] interval;
  modport master (output pulse_in, input freq_code, code_valid, mismatch, interval);
  modport slave  (input pulse_in, output freq_code, code_valid, mismatch, interval);
endinterface

// File: rtl/rate_decoder.sv
// rate_decoder: measures the cycle interval between ticks and locks onto one of four rate codes
//   CLOCK_50 : sole clock, posedge
//   clear    : synchronous active-high reset
//   bus      : rate_decoder_if slave (pulse_in in; freq_code, code_valid, mismatch, interval out)
module rate_decoder #(
  parameter int PERIOD_1 = 50000000,
  parameter int PERIOD_2 = 100000000,
  parameter int PERIOD_4 = 200000000,
  parameter int TOL      = 1000,
  parameter int CNT_W    = 28
) (
  input logic           CLOCK_50,
  input logic           clear,
  rate_decoder_if.slave bus
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [CNT_W:0]   P1  = (CNT_W+1)'(PERIOD_1);
  localparam logic [CNT_W:0]   P2  = (CNT_W+1)'(PERIOD_2);
  localparam logic [CNT_W:0]   P4  = (CNT_W+1)'(PERIOD_4);
  localparam logic [CNT_W:0]   TW  = (CNT_W+1)'(TOL);
  // Timeout fires on the edge where the counter would step onto PERIOD_4+TOL.
  localparam logic [CNT_W-1:0] TO  = CNT_W'(PERIOD_4 + TOL - 1);
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, interval_q;
  logic [1:0]       cand_q, code_q, cls_d;
  logic             cand_ok_q, valid_q, mis_q, hit_d, w1_d, w2_d, w4_d;
  function automatic logic in_win(logic [CNT_W:0] c, logic [CNT_W:0] p);
    logic [CNT_W:0] diff;
    diff = c >= p ? c - p : p - c;
    return diff <= TW;
  endfunction
  always_comb begin
    w1_d  = in_win({1'b0, cnt_q}, P1);
    w2_d  = in_win({1'b0, cnt_q}, P2);
    w4_d  = in_win({1'b0, cnt_q}, P4);
    hit_d = cnt_q == CNT_W'(1) || w1_d || w2_d || w4_d;
    cls_d = cnt_q == CNT_W'(1) ? 2'b00 : w1_d ? 2'b01 : w2_d ? 2'b10 : 2'b11;
  end
  always_ff @(posedge CLOCK_50) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      cand_ok_q  <= 1'b0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      interval_q <= '0;
    end else if (state_q == IDLE) begin
      if (bus.pulse_in) begin
        state_q <= MEASURE;
        cnt_q   <= CNT_W'(1);
      end
    end else if (bus.pulse_in) begin
      interval_q <= cnt_q;
      cnt_q      <= CNT_W'(1);
      if (!hit_d) begin
        cand_ok_q <= 1'b0;
        valid_q   <= 1'b0;
        mis_q     <= 1'b1;
      end else if (cand_ok_q && cls_d == cand_q) begin
        code_q  <= cls_d;
        valid_q <= 1'b1;
        mis_q   <= 1'b0;
      end else begin
        cand_q    <= cls_d;
        cand_ok_q <= 1'b1;
        valid_q   <= 1'b0;
        mis_q     <= 1'b0;
      end
    end else if (cnt_q == TO) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      mis_q     <= 1'b1;
      cand_ok_q <= 1'b0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign bus.freq_code  = code_q;
  assign bus.code_valid = valid_q;
  assign bus.mismatch   = mis_q;
  assign bus.interval   = interval_q;
endmodule

// File: tb/tb_rate_decoder.sv
// tb_rate_decoder: directed ticks checked every cycle against a tick-time model, plus literal expectations
module tb_rate_decoder;
  localparam int P1 = 10, P2 = 20, P4 = 40, TOL = 2, W = 8;
  logic CLOCK_50 = 1'b0;
  logic clear;
  int   chk = 0, pass = 0;
  rate_decoder_if #(.CNT_W(W)) bus ();
  rate_decoder #(.PERIOD_1(P1), .PERIOD_2(P2), .PERIOD_4(P4), .TOL(TOL), .CNT_W(W))
    dut (.CLOCK_50(CLOCK_50), .clear(clear), .bus(bus));
  always #5 CLOCK_50 = ~CLOCK_50;
  wire [11:0] dut_vec = {bus.freq_code, bus.code_valid, bus.mismatch, bus.interval};
  // model: remembers when the last tick was seen and the class of the previous interval
  int         e = 0, last = 0, prev = -1, k, c;
  bit         have = 0, armed = 0;
  logic [1:0] m_code = 0;
  logic       m_valid = 0, m_mis = 0;
  logic [7:0] m_int = 0;
  function automatic int classify(int n);
    int d1, d2, d4;
    d1 = n > P1 ? n - P1 : P1 - n;
    d2 = n > P2 ? n - P2 : P2 - n;
    d4 = n > P4 ? n - P4 : P4 - n;
    if (n == 1) return 0;
    if (d1 <= TOL) return 1;
    if (d2 <= TOL) return 2;
    if (d4 <= TOL) return 3;
    return -1;
  endfunction
  always @(posedge CLOCK_50) begin
    e++;
    if (clear) begin
      armed = 1; have = 0; prev = -1;
      m_code = 0; m_valid = 0; m_mis = 0; m_int = 0;
    end else if (bus.pulse_in) begin
      if (have) begin
        k = e - last;
        c = classify(k);
        m_int = 8'(k);
        if (c < 0) begin
          prev = -1; m_valid = 0; m_mis = 1;
        end else if (c == prev) begin
          m_code = 2'(c); m_valid = 1; m_mis = 0;
        end else begin
          prev = c; m_valid = 0; m_mis = 0;
        end
      end
      have = 1;
      last = e;
    end else if (have && e - last == P4 + TOL - 1) begin
      have = 0; prev = -1; m_valid = 0; m_mis = 1;
    end
  end
  task automatic check(string name, logic [11:0] got, logic [11:0] exp);
    chk++;
    if (got === exp) pass++;
    else $display("FAIL %s t=%0t got code/valid/mis/int=%h expected=%h", name, $time, got, exp);
  endtask
  always @(negedge CLOCK_50)
    if (armed) check("model", dut_vec, {m_code, m_valid, m_mis, m_int});
  task automatic lit(string name, logic [1:0] cd, logic v, logic m, logic [7:0] i);
    check(name, dut_vec, {cd, v, m, i});
  endtask
  // k cycles after the previous tick (which was followed by one low cycle), present one tick
  task automatic tick(int k);
    repeat (k - 2) begin
      @(negedge CLOCK_50);
      bus.pulse_in = 1'b0;
    end
    @(negedge CLOCK_50);
    bus.pulse_in = 1'b1;
    @(negedge CLOCK_50);
    bus.pulse_in = 1'b0;
  endtask
  initial begin
    clear = 1'b1;
    bus.pulse_in = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    lit("reset", 2'd0, 1'b0, 1'b0, 8'd0);
    clear = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    lit("hold_high_lock", 2'd0, 1'b1, 1'b0, 8'd1);
    bus.pulse_in = 1'b0;
    repeat (3) tick(10);
    lit("lock_01", 2'd1, 1'b1, 1'b0, 8'd10);
    repeat (3) tick(21);
    lit("lock_10", 2'd2, 1'b1, 1'b0, 8'd21);
    repeat (3) tick(38);
    lit("lock_11", 2'd3, 1'b1, 1'b0, 8'd38);
    tick(12);
    lit("tol_edge_in", 2'd3, 1'b0, 1'b0, 8'd12);
    tick(13);
    lit("tol_edge_out", 2'd3, 1'b0, 1'b1, 8'd13);
    repeat (2) tick(8);
    lit("relock_01", 2'd1, 1'b1, 1'b0, 8'd8);
    tick(20);
    lit("class_change_drop", 2'd1, 1'b0, 1'b0, 8'd20);
    tick(20);
    lit("class_change_lock", 2'd2, 1'b1, 1'b0, 8'd20);
    repeat (2) tick(40);
    lit("lock_11_again", 2'd3, 1'b1, 1'b0, 8'd40);
    tick(41);
    lit("tick_on_timeout_edge", 2'd3, 1'b1, 1'b0, 8'd41);
    repeat (40) @(negedge CLOCK_50);
    lit("before_timeout", 2'd3, 1'b1, 1'b0, 8'd41);
    @(negedge CLOCK_50);
    lit("timeout", 2'd3, 1'b0, 1'b1, 8'd41);
    tick(5);
    lit("first_after_timeout", 2'd3, 1'b0, 1'b1, 8'd41);
    tick(40);
    lit("second_after_timeout", 2'd3, 1'b0, 1'b0, 8'd40);
    tick(40);
    lit("third_after_timeout", 2'd3, 1'b1, 1'b0, 8'd40);
    repeat (3) @(negedge CLOCK_50);
    clear = 1'b1;
    bus.pulse_in = 1'b1;
    @(negedge CLOCK_50);
    clear = 1'b0;
    bus.pulse_in = 1'b0;
    lit("mid_clear", 2'd0, 1'b0, 1'b0, 8'd0);
    repeat (3) tick(10);
    lit("lock_after_clear", 2'd1, 1'b1, 1'b0, 8'd10);
    repeat (3) @(negedge CLOCK_50);
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
